rgb_sram_pixel_fetch: RTL
=========================

Name: rgb_sram_pixel_fetch

Overview:
Downstream consumer of the YUV-to-RGB upsampling/colour-space stage. Reads the packed RGB image that stage writes to external SRAM. Unpacks each 3-word group (2 pixels) into 24-bit pixels. Streams pixels through a small FIFO, with a valid/ready handshake, to the VGA output path.

Parameters:
RGB_BASE, 18'd146944, SRAM word address of the first packed RGB word
NUM_PIXELS, 17'd76800, pixels per frame (320x240); must be even
FIFO_DEPTH, 8, pixel FIFO entries; power of two, >= 4

Ports:
Clock  in  1  system clock, all logic on rising edge
Reset  in  1  asynchronous, active-high reset
Enable  in  1  start pulse; sampled only in S_IDLE
SRAM_address  out  18  registered SRAM read address
SRAM_read_data  in  16  SRAM data; valid 2 cycles after the edge that loads SRAM_address
SRAM_we_n  out  1  SRAM write enable, active low; held 1 (read-only block)
Pixel_R  out  8  red of FIFO head
Pixel_G  out  8  green of FIFO head
Pixel_B  out  8  blue of FIFO head
Pixel_valid  out  1  FIFO non-empty
Pixel_ready  in  1  consumer accepts head when high with Pixel_valid
Pixel_last  out  1  head is pixel NUM_PIXELS-1
Busy  out  1  high from accepted Enable until Done
Done  out  1  one-cycle pulse after last pixel handshake

Behaviour:
- Reset (async, any time incl. mid-frame): state S_IDLE; SRAM_address=RGB_BASE; SRAM_we_n=1; FIFO emptied; in-flight read tags cleared; all counters 0; Pixel_valid=0; Pixel_last=0; Busy=0; Done=0. Pixel_R/G/B are don't-care while Pixel_valid=0.
- Packing per pixel pair k, words at RGB_BASE+3k:
  - w0={R0,G0}
  - w1={B0,R1}
  - w2={G1,B1}
  - High byte is [15:8].
- States:
  - S_IDLE: Enable=1 -> S_ISSUE, Busy<=1, word counter 0, pixel counters 0.
  - S_ISSUE: if credit available, issue w0,w1,w2 on 3 consecutive cycles, SRAM_address incrementing by 1. Otherwise hold the address and stall in S_ISSUE. A triplet is never split.
  - After the last triplet (3*NUM_PIXELS/2 words) is issued -> S_DRAIN.
  - S_DRAIN: wait until all pixels are popped -> S_DONE.
  - S_DONE: Done=1 for one cycle, Busy<=0 -> S_IDLE.
- Credit rule: a triplet may start only if (FIFO count + pixels reserved by in-flight triplets + 2) <= FIFO_DEPTH. Overflow is therefore impossible; no push is ever dropped.
- Read return: a 2-stage tag shift register (valid plus word index 0/1/2) aligns with SRAM_read_data.
  - w0 return: latch R0,G0.
  - w1 return: push {R0,G0,B0=[15:8]}; latch R1=[7:0].
  - w2 return: push {R1,G1=[15:8],B1=[7:0]}.
- FIFO: circular buffer; head/tail pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pop on empty cannot occur, since Pixel_valid gates the pop.
- Output handshake: a pop occurs when Pixel_valid and Pixel_ready are both 1.
  - Pixel_R/G/B and Pixel_last are stable while Pixel_valid=1 and Pixel_ready=0.
  - First-word fall-through: a pixel pushed at edge n is visible at the head after edge n.
- Pixel_last: derived from the pop counter == NUM_PIXELS-1 while Pixel_valid.
- Done: asserted the cycle after the pop of the last pixel, never earlier.
- Enable while Busy=1: ignored.
- Latency: first Pixel_valid 4 cycles after the Enable edge (1 to enter S_ISSUE, 2 SRAM, w1 push).
- Throughput: 2 pixels per 3 cycles when the consumer never stalls.

Optional Feature:
Macro RGB_FETCH_UNDERRUN_CNT_EN.
- Defined:
  - Adds output Underrun_count [15:0].
  - Counts cycles with Busy=1, state != S_DRAIN/S_DONE, Pixel_ready=1 and Pixel_valid=0.
  - Saturates at 16'hFFFF; cleared by Reset and on accepted Enable.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then Enable with SRAM model words 0x1122,0x3344,0x5566 at 146944..146946, Pixel_ready=1 -> pixels {11,22,33} then {44,55,66}; first Pixel_valid 4 cycles after Enable.
- Full frame (NUM_PIXELS=76800), Pixel_ready=1 -> 115200 reads at addresses 146944..262143 in order; Pixel_last only on pixel 76799; Done one cycle after that pop; Busy falls with Done.
- Pixel_ready=0 for 50 cycles mid-frame -> FIFO fills to 8 and issue stalls; no address skipped; outputs stable; stream resumes with no lost or duplicated pixel.
- Random Pixel_ready (50%) over a frame with NUM_PIXELS=16 -> output matches the reference unpack; FIFO count never exceeds FIFO_DEPTH.
- Reset asserted mid-frame with 5 pixels in the FIFO -> Pixel_valid=0, Busy=0, SRAM_address=146944 immediately; a new Enable restarts from pixel 0.
- With RGB_FETCH_UNDERRUN_CNT_EN: Pixel_ready=1 from Enable -> Underrun_count=4 after first valid (startup empty cycles); Enable while Busy has no effect.

Source files
------------

// File: rtl/rgb_sram_pixel_fetch.sv
// RGB SRAM pixel fetch: reads the packed RGB frame (3 words per pixel pair) from SRAM,
// unpacks it into 24-bit pixels and streams them through a small FWFT FIFO with a
// valid/ready handshake.
// Optional build macro RGB_FETCH_UNDERRUN_CNT_EN adds the Underrun_count output.
module rgb_sram_pixel_fetch #(
  parameter logic [17:0] RGB_BASE   = 18'd146944,
  parameter logic [16:0] NUM_PIXELS = 17'd76800,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Enable,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic        SRAM_we_n,
  output logic [7:0]  Pixel_R,
  output logic [7:0]  Pixel_G,
  output logic [7:0]  Pixel_B,
  output logic        Pixel_valid,
  input  logic        Pixel_ready,
  output logic        Pixel_last,
  output logic        Busy,
`ifdef RGB_FETCH_UNDERRUN_CNT_EN
  output logic [15:0] Underrun_count,
`endif
  output logic        Done
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [16:0] LAST_WORD  = 17'((3 * int'(NUM_PIXELS)) / 2 - 1);
  localparam logic [16:0] LAST_PIXEL = NUM_PIXELS - 17'd1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;
  logic [17:0] addr_q, addr_d;
  logic [16:0] word_cnt_q, word_cnt_d;
  logic [1:0]  phase_q, phase_d;
  logic [16:0] pop_cnt_q, pop_cnt_d;
  logic        busy_q, busy_d;
  logic [CNT_W-1:0] resv_q, resv_d;
  logic        issue, start_trip, credit_ok;
  logic [SUM_W-1:0] occ_sum;

  // Read-tag pipeline: two stages line up with the SRAM's two-cycle read latency
  logic [1:0]  tag_vld_q;
  logic [1:0]  tag_idx0_q, tag_idx1_q;
  logic [15:0] r0g0_q;
  logic [7:0]  r1_q;
  logic        push, pop;
  logic [23:0] push_data;

  logic [23:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q, count_d;

  // Pixels already in the FIFO plus those owed by in-flight triplets must leave room for 2 more
  assign occ_sum   = SUM_W'(count_q) + SUM_W'(resv_q) + SUM_W'(2);
  assign credit_ok = occ_sum <= SUM_W'(FIFO_DEPTH);

  assign pop         = Pixel_valid && Pixel_ready;
  assign Pixel_valid = count_q != '0;
  assign Pixel_last  = Pixel_valid && (pop_cnt_q == LAST_PIXEL);
  assign {Pixel_R, Pixel_G, Pixel_B} = fifo_mem[head_q];
  assign SRAM_address = addr_q;
  assign SRAM_we_n    = 1'b1;
  assign Busy         = busy_q;
  assign Done         = state_q == S_DONE;

  // Next-state and issue control
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    word_cnt_d = word_cnt_q;
    phase_d    = phase_q;
    busy_d     = busy_q;
    pop_cnt_d  = pop ? pop_cnt_q + 17'd1 : pop_cnt_q;
    issue      = 1'b0;
    start_trip = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Enable) begin
          state_d    = S_ISSUE;
          busy_d     = 1'b1;
          addr_d     = RGB_BASE;
          word_cnt_d = '0;
          phase_d    = '0;
          pop_cnt_d  = '0;
        end
      end
      S_ISSUE: begin
        // Credit is only checked at w0 so a triplet is never split
        if (phase_q != 2'd0 || credit_ok) begin
          issue      = 1'b1;
          start_trip = phase_q == 2'd0;
          addr_d     = addr_q + 18'd1;
          word_cnt_d = word_cnt_q + 17'd1;
          phase_d    = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
          if (word_cnt_q == LAST_WORD) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && pop_cnt_q == LAST_PIXEL) state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        addr_d  = RGB_BASE;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      addr_q     <= RGB_BASE;
      word_cnt_q <= '0;
      phase_q    <= '0;
      pop_cnt_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_cnt_q <= word_cnt_d;
      phase_q    <= phase_d;
      pop_cnt_q  <= pop_cnt_d;
      busy_q     <= busy_d;
    end
  end

  // Read-return unpack: w1 and w2 each complete one pixel
  always_comb begin
    push      = tag_vld_q[1] && (tag_idx1_q != 2'd0);
    push_data = (tag_idx1_q == 2'd1) ? {r0g0_q, SRAM_read_data[15:8]}
                                     : {r1_q, SRAM_read_data};
  end

  // Tag pipeline and partial-pixel latches
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      tag_vld_q  <= '0;
      tag_idx0_q <= '0;
      tag_idx1_q <= '0;
      r0g0_q     <= '0;
      r1_q       <= '0;
    end else begin
      tag_vld_q  <= {tag_vld_q[0], issue};
      tag_idx0_q <= phase_q;
      tag_idx1_q <= tag_idx0_q;
      if (tag_vld_q[1] && tag_idx1_q == 2'd0) r0g0_q <= SRAM_read_data;
      if (tag_vld_q[1] && tag_idx1_q == 2'd1) r1_q   <= SRAM_read_data[7:0];
    end
  end

  // Pixels reserved by triplets in flight, and FIFO occupancy
  always_comb begin
    resv_d = resv_q;
    if (start_trip) resv_d = resv_d + CNT_W'(2);
    if (push)       resv_d = resv_d - CNT_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and counters
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      resv_q  <= '0;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      resv_q  <= resv_d;
      count_q <= count_d;
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
    end
  end

  // FIFO storage; contents are don't-care while empty so no reset
  always_ff @(posedge Clock) begin
    if (push) fifo_mem[tail_q] <= push_data;
  end

`ifdef RGB_FETCH_UNDERRUN_CNT_EN
  logic [15:0] underrun_q;
  assign Underrun_count = underrun_q;

  // Saturating count of cycles the consumer was ready but starved while fetching
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      underrun_q <= '0;
    end else if (state_q == S_IDLE && Enable) begin
      underrun_q <= '0;
    end else if (busy_q && state_q != S_DRAIN && state_q != S_DONE && Pixel_ready &&
                 !Pixel_valid && underrun_q != 16'hFFFF) begin
      underrun_q <= underrun_q + 16'd1;
    end
  end
`endif

endmodule
